// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: shares one sync_fifo write port among NREQ producers,
// granting bursts of up to BURST words and stalling the owner while the FIFO is full.
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          ack,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     busy,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_din
);
  localparam int OW = $clog2(NREQ);
  localparam int CW = $clog2(BURST+1);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [OW-1:0]   owner_q, owner_d, rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   burst_cnt_q, burst_cnt_d;

  logic [OW-1:0]   owner_nxt, pick_start, pick_idx;
  logic            pick_vld, wr, release_own;

  assign owner_nxt   = (owner_q == OW'(NREQ-1)) ? '0 : owner_q + 1'b1;
  assign wr          = (state_q == OWN) & req[owner_q] & ~fifo_full & ~rst;
  assign release_own = (state_q == OWN) &
                       (~req[owner_q] | (wr & (burst_cnt_q == CW'(BURST-1))));
  // On release the scan starts just past the outgoing owner, so it wins only if alone.
  assign pick_start  = release_own ? owner_nxt : rr_ptr_q;

  // Descending scan: the last hit is the closest to pick_start in circular order.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (req[(int'(pick_start) + k) % NREQ]) begin
        pick_vld = 1'b1;
        pick_idx = OW'((int'(pick_start) + k) % NREQ);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d           = OWN;
          gnt_d             = '0;
          gnt_d[pick_idx]   = 1'b1;
          owner_d           = pick_idx;
          burst_cnt_d       = '0;
        end
      end
      OWN: begin
        if (wr) burst_cnt_d = burst_cnt_q + 1'b1;
        if (release_own) begin
          rr_ptr_d = owner_nxt;
          if (pick_vld) begin
            gnt_d           = '0;
            gnt_d[pick_idx] = 1'b1;
            owner_d         = pick_idx;
            burst_cnt_d     = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign gnt        = gnt_q;
  assign owner      = owner_q;
  assign busy       = (state_q == OWN);
  assign fifo_wr_en = wr;
  assign ack        = wr ? gnt_q : '0;
  assign fifo_din   = req_data[owner_q*WIDTH +: WIDTH];

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a 16-deep FIFO model and per-requester word sources.
module tb_fifo_wr_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt, ack;
  logic [1:0]  owner;
  logic        busy, fifo_full, fifo_wr_en;
  logic [7:0]  fifo_din;

  fifo_wr_arbiter #(.NREQ(4), .WIDTH(8), .BURST(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt), .ack(ack),
    .owner(owner), .busy(busy), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_din(fifo_din)
  );

  always #5 clk = ~clk;

  int         n_chk = 0, n_fail = 0;
  int         ptr[4], lim[4];
  logic [7:0] base[4];
  logic       rd, force_full;
  logic [7:0] fq[$], outq[$], all_w[$];
  int         ackq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive inputs at the falling edge, then let combinational outputs settle.
  task automatic settle();
    for (int i = 0; i < 4; i++) begin
      req[i]            = (ptr[i] < lim[i]);
      req_data[i*8 +: 8] = base[i] + 8'(ptr[i]);
    end
    fifo_full = force_full || (fq.size() >= 16);
    #1;
  endtask

  // Record this cycle's FIFO traffic just before the rising edge, then wait for the next fall.
  task automatic adv();
    #3;
    if (rd && fq.size() > 0) outq.push_back(fq.pop_front());
    if (fifo_wr_en) fq.push_back(fifo_din);
    for (int i = 0; i < 4; i++)
      if (ack[i]) begin
        ackq.push_back(i);
        ptr[i]++;
      end
    @(negedge clk);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 4; i++) begin ptr[i] = 0; lim[i] = 0; base[i] = 8'h00; end
    rd = 1'b0; force_full = 1'b0;
    fq.delete(); outq.delete(); ackq.delete();
    rst = 1'b1;
    settle(); chk("rst_wr_en", fifo_wr_en, 0); chk("rst_ack", ack, 0); adv();
    settle(); chk("rst_gnt", gnt, 0); chk("rst_busy", busy, 0); chk("rst_owner", owner, 0); adv();
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    settle();
    while ((busy || req != 4'b0) && n < 200) begin
      adv(); settle(); n++;
    end
    chk(tag, 32'(busy || req != 4'b0), 0);
    adv();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = '0; req_data = '0; rd = 1'b0; force_full = 1'b0; fifo_full = 1'b0;
    @(negedge clk);

    // 1: single requester, 6 words, re-granted to itself after word 4 with no bubble
    do_reset();
    base[0] = 8'h10; lim[0] = 6;
    settle(); chk("t1_gnt_lat", gnt, 0); adv();
    for (int k = 0; k < 6; k++) begin
      settle();
      chk($sformatf("t1_ack%0d", k), ack, 4'b0001);
      chk($sformatf("t1_din%0d", k), fifo_din, 32'h10 + k);
      adv();
    end
    settle(); chk("t1_drop_busy", busy, 1); chk("t1_drop_wr", fifo_wr_en, 0); adv();
    settle(); chk("t1_idle_busy", busy, 0); chk("t1_idle_gnt", gnt, 0); adv();
    chk("t1_fifo_cnt", fq.size(), 6);
    for (int k = 0; k < 6; k++) chk($sformatf("t1_fifo%0d", k), fq[k], 32'h10 + k);

    // 2: all four requesting, 8 words each: order 0,1,2,3,0,1,2,3 in 4-word bursts
    do_reset();
    rd = 1'b1;
    for (int i = 0; i < 4; i++) begin base[i] = 8'(i << 4); lim[i] = 8; end
    settle(); chk("t2_gnt_lat", gnt, 0); adv();
    for (int k = 0; k < 32; k++) begin
      settle();
      chk($sformatf("t2_ack%0d", k), ack, 32'(1 << ((k / 4) % 4)));
      adv();
    end
    drain("t2_idle_timeout");
    chk("t2_out_cnt", outq.size(), 32);
    for (int k = 0; k < 16; k++)
      chk($sformatf("t2_word%0d", k), outq[k], 32'((((k / 4) % 4) << 4) | (k % 4)));

    // 3: FIFO goes full after requester 2's first word; stall, then resume with 3 more
    do_reset();
    for (int k = 0; k < 15; k++) fq.push_back(8'hEE);
    base[2] = 8'h20; lim[2] = 4; base[3] = 8'h30; lim[3] = 1;
    settle(); chk("t3_gnt_lat", gnt, 0); adv();
    settle(); chk("t3_first_ack", ack, 4'b0100); chk("t3_first_wr", fifo_wr_en, 1); adv();
    for (int k = 0; k < 3; k++) begin
      settle();
      chk($sformatf("t3_stall_wr%0d", k), fifo_wr_en, 0);
      chk($sformatf("t3_stall_ack%0d", k), ack, 0);
      chk($sformatf("t3_stall_gnt%0d", k), gnt, 4'b0100);
      adv();
    end
    rd = 1'b1;
    drain("t3_idle_timeout");
    chk("t3_ack_cnt", ackq.size(), 5);
    for (int k = 0; k < 5 && k < ackq.size(); k++)
      chk($sformatf("t3_ackseq%0d", k), ackq[k], (k < 4) ? 2 : 3);
    all_w = {outq, fq};
    chk("t3_words", all_w.size(), 20);
    for (int k = 0; k < 5 && 15 + k < all_w.size(); k++)
      chk($sformatf("t3_word%0d", k), all_w[15+k], (k < 4) ? 32'h20 + k : 32'h30);

    // 4: requester 1 drops after 2 words, requester 3 takes over
    do_reset();
    rd = 1'b1;
    base[1] = 8'h10; lim[1] = 2; base[3] = 8'h30; lim[3] = 2;
    settle(); chk("t4_gnt_lat", gnt, 0); adv();
    settle(); chk("t4_ack0", ack, 4'b0010); chk("t4_din0", fifo_din, 8'h10); adv();
    settle(); chk("t4_ack1", ack, 4'b0010); chk("t4_din1", fifo_din, 8'h11); adv();
    settle(); chk("t4_rel_wr", fifo_wr_en, 0); chk("t4_rel_gnt", gnt, 4'b0010); adv();
    settle(); chk("t4_new_gnt", gnt, 4'b1000); chk("t4_new_din", fifo_din, 8'h30); adv();
    drain("t4_idle_timeout");
    all_w = {outq, fq};
    chk("t4_words", all_w.size(), 4);
    for (int k = 0; k < 4 && k < all_w.size(); k++)
      chk($sformatf("t4_word%0d", k), all_w[k], (k < 2) ? 32'h10 + k : 32'h2E + k);

    // 5: reset mid-burst of requester 2, then requester 0 wins from rr_ptr=0
    do_reset();
    base[2] = 8'h20; lim[2] = 8;
    settle(); adv();
    settle(); chk("t5_ack0", ack, 4'b0100); adv();
    settle(); chk("t5_ack1", ack, 4'b0100); adv();
    rst = 1'b1; lim[0] = 4;
    settle(); chk("t5_rst_wr", fifo_wr_en, 0); chk("t5_rst_ack", ack, 0); adv();
    chk("t5_fifo_cnt", fq.size(), 2);
    rst = 1'b0;
    settle(); chk("t5_post_gnt", gnt, 0); chk("t5_post_busy", busy, 0); adv();
    settle(); chk("t5_first_gnt", gnt, 4'b0001); chk("t5_first_owner", owner, 0); adv();

    // 6: no requests for 20 cycles, FIFO full for the second half
    do_reset();
    begin
      logic bad_busy, bad_gnt, bad_wr;
      bad_busy = 0; bad_gnt = 0; bad_wr = 0;
      for (int k = 0; k < 20; k++) begin
        force_full = (k >= 10);
        settle();
        bad_busy |= busy; bad_gnt |= (gnt != 0); bad_wr |= fifo_wr_en;
        adv();
      end
      chk("t6_busy", bad_busy, 0);
      chk("t6_gnt", bad_gnt, 0);
      chk("t6_wr", bad_wr, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
